// File: rtl/u_insn_sequencer.sv
// rtl/u_insn_sequencer.sv - multi-cycle control sequencer for RISC-V U-type instructions (LUI, AUIPC)
//
// Purpose:
//    Accepts one instruction per i_start handshake in IDLE, then walks
//    DECODE -> EXEC -> WB (or DECODE -> ERR for a non-U-type opcode).
//    It computes the destination value internally and issues a single
//    register-file write strobe in WB.
//
// Optional feature macro: U_SEQ_STALL_EN
//    When defined, the block gains an i_stall input. Stall freezes
//    DECODE/EXEC/WB and suppresses rd_we/done while WB is held.
//
// Parameters:
//    XLEN  datapath width (32 or 64)
//    RD_W  destination register index width
//
// Ports:
//    i_clk          processor clock, rising edge
//    i_rst          synchronous active-high reset
//    i_start        instruction valid, sampled only in IDLE
//    i_insn         instruction word, latched on accepted start
//    i_pc           address of i_insn, latched on accepted start
//    i_stall        (U_SEQ_STALL_EN only) hold DECODE/EXEC/WB
//    o_busy         state is not IDLE
//    o_done         one-cycle pulse in WB
//    o_illegal      one-cycle pulse in ERR
//    o_rd_we        register-file write strobe, suppressed for x0
//    o_rd_addr      destination register index, insn[11:7]
//    o_rd_data      value to write, registered in EXEC
//    o_addr_sel, o_pc_next_sel, o_pc_alu_sel, o_sub_sra, o_mem_we
//                   datapath controls, constant 0 for U-type
module u_insn_sequencer #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [31:0]     i_insn,
   input  logic [XLEN-1:0] i_pc,
`ifdef U_SEQ_STALL_EN
   input  logic            i_stall,
`endif
   output logic            o_busy,
   output logic            o_done,
   output logic            o_illegal,
   output logic            o_rd_we,
   output logic [RD_W-1:0] o_rd_addr,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_addr_sel,
   output logic            o_pc_next_sel,
   output logic            o_pc_alu_sel,
   output logic            o_sub_sra,
   output logic            o_mem_we
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [31:0]       r_insn;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_rd_data;
   logic              w_stall;
   logic              w_is_u_type;
   logic signed [31:0] w_imm32;
   logic [XLEN-1:0]   w_imm;
   logic [XLEN-1:0]   w_result;

`ifdef U_SEQ_STALL_EN
   assign w_stall = i_stall;
`else
   assign w_stall = 1'b0;
`endif

   assign w_is_u_type = (r_insn[6:0] == OP_LUI) || (r_insn[6:0] == OP_AUIPC);

   // Signed size cast sign-extends the 32-bit upper immediate to XLEN.
   assign w_imm32  = $signed({r_insn[31:12], 12'b0});
   assign w_imm    = XLEN'(w_imm32);
   // Carry out of the AUIPC add is discarded by the XLEN-wide sum.
   assign w_result = (r_insn[6:0] == OP_LUI) ? w_imm : (r_pc + w_imm);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_insn    <= '0;
         r_pc      <= '0;
         r_rd_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && i_start) begin
            r_insn <= i_insn;
            r_pc   <= i_pc;
         end
         if (r_state == S_EXEC && !w_stall) begin
            r_rd_data <= w_result;
         end
      end
   end

   // Stall only freezes the three working states; IDLE and ERR always move on.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_state_next = S_DECODE;
         S_DECODE: if (!w_stall) w_state_next = w_is_u_type ? S_EXEC : S_ERR;
         S_EXEC:   if (!w_stall) w_state_next = S_WB;
         S_WB:     if (!w_stall) w_state_next = S_IDLE;
         S_ERR:    w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_WB) && !w_stall;
   assign o_illegal     = (r_state == S_ERR);
   assign o_rd_addr     = RD_W'(r_insn[11:7]);
   assign o_rd_we       = o_done && (o_rd_addr != '0);
   assign o_rd_data     = r_rd_data;
   assign o_addr_sel    = 1'b0;
   assign o_pc_next_sel = 1'b0;
   assign o_pc_alu_sel  = 1'b0;
   assign o_sub_sra     = 1'b0;
   assign o_mem_we      = 1'b0;

endmodule

// File: tb/tb_u_insn_sequencer.sv
// tb/tb_u_insn_sequencer.sv - directed self-checking bench for u_insn_sequencer (XLEN 32 and 64)
module tb_u_insn_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] insn;
   logic [31:0] pc32;
   logic [63:0] pc64;
`ifdef U_SEQ_STALL_EN
   logic        stall;
`endif

   logic        busy32, done32, ill32, we32;
   logic [4:0]  addr32;
   logic [31:0] data32;
   logic        as32, pns32, pas32, ss32, mw32;

   logic        busy64, done64, ill64, we64;
   logic [4:0]  addr64;
   logic [63:0] data64;
   logic        as64, pns64, pas64, ss64, mw64;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int snap;

   always #5 clk = ~clk;

   u_insn_sequencer #(.XLEN(32), .RD_W(5)) u_dut32 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_insn(insn), .i_pc(pc32),
`ifdef U_SEQ_STALL_EN
      .i_stall(stall),
`endif
      .o_busy(busy32), .o_done(done32), .o_illegal(ill32), .o_rd_we(we32),
      .o_rd_addr(addr32), .o_rd_data(data32), .o_addr_sel(as32),
      .o_pc_next_sel(pns32), .o_pc_alu_sel(pas32), .o_sub_sra(ss32), .o_mem_we(mw32)
   );

   u_insn_sequencer #(.XLEN(64), .RD_W(5)) u_dut64 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_insn(insn), .i_pc(pc64),
`ifdef U_SEQ_STALL_EN
      .i_stall(stall),
`endif
      .o_busy(busy64), .o_done(done64), .o_illegal(ill64), .o_rd_we(we64),
      .o_rd_addr(addr64), .o_rd_data(data64), .o_addr_sel(as64),
      .o_pc_next_sel(pns64), .o_pc_alu_sel(pas64), .o_sub_sra(ss64), .o_mem_we(mw64)
   );

   // Count done pulses of the 32-bit instance, sampled mid-cycle.
   always @(negedge clk) if (done32 === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction and let the edge E0 accept it; returns just after E0.
   task automatic accept(input logic [31:0] w, input logic [31:0] p32, input logic [63:0] p64);
      insn  = w;
      pc32  = p32;
      pc64  = p64;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      insn  = 32'h123452B7;
      pc32  = '0;
      pc64  = '0;
`ifdef U_SEQ_STALL_EN
      stall = 1'b0;
`endif
      // Reset, with start held high alongside it.
      step();
      step();
      chk("rst_busy", busy32, 0);
      chk("rst_done", done32, 0);
      chk("rst_illegal", ill32, 0);
      chk("rst_rd_we", we32, 0);
      chk("rst_rd_addr", addr32, 0);
      chk("rst_rd_data", data32, 0);
      chk("rst_rd_data64", data64, 0);
      chk("ctrl_zero", {as32, pns32, pas32, ss32, mw32}, 0);
      rst   = 1'b0;
      start = 1'b0;
      step();
      chk("rst_start_ignored", busy32, 0);

      // LUI x5, 0x12345; input insn is changed after acceptance to prove latching.
      accept(32'h123452B7, 32'h0, 64'h0);
      insn = 32'h00000013;
      chk("lui_busy_e0", busy32, 1);
      chk("lui_done_e0", done32, 0);
      step();
      chk("lui_we_e1", we32, 0);
      step();
      chk("lui_done_wb", done32, 1);
      chk("lui_we_wb", we32, 1);
      chk("lui_addr_wb", addr32, 5);
      chk("lui_data_wb", data32, 32'h12345000);
      chk("lui_data64_wb", data64, 64'h0000000012345000);
      step();
      chk("lui_done_e3", done32, 0);
      chk("lui_busy_e3", busy32, 0);
      chk("lui_data_hold", data32, 32'h12345000);

      // AUIPC x10, 1 with 32-bit wrap; 64-bit instance carries into bit 32.
      accept(32'h00001517, 32'hFFFFF000, 64'h00000000FFFFF000);
      step();
      step();
      chk("auipc_wrap_data", data32, 32'h00000000);
      chk("auipc_wrap_data64", data64, 64'h0000000100000000);
      chk("auipc_wrap_addr", addr32, 10);
      chk("auipc_wrap_we", we32, 1);
      step();

      // AUIPC x3, 0x80000: negative immediate, sign-extended at 64 bits.
      accept(32'h80000197, 32'h00001000, 64'h0000000000001000);
      step();
      step();
      chk("auipc_neg_data64", data64, 64'hFFFFFFFF80001000);
      chk("auipc_neg_data", data32, 32'h80001000);
      chk("auipc_neg_addr", addr64, 3);
      step();

      // LUI x0: done pulses, write suppressed.
      accept(32'hABCDE037, 32'h0, 64'h0);
      step();
      step();
      chk("x0_done", done32, 1);
      chk("x0_we", we32, 0);
      chk("x0_data64", data64, 64'hFFFFFFFFABCDE000);
      step();

      // Illegal opcode (addi x0,x0,0).
      snap = done_cnt;
      accept(32'h00000013, 32'h0, 64'h0);
      chk("ill_e0", ill32, 0);
      step();
      chk("ill_pulse", ill32, 1);
      chk("ill_busy_e1", busy32, 1);
      chk("ill_we", we32, 0);
      step();
      chk("ill_clear", ill32, 0);
      chk("ill_busy_e2", busy32, 0);
      chk("ill_no_done", done_cnt - snap, 0);
      chk("ill_data_hold", data32, 32'hABCDE000);

      // start held through the whole run: ignored while busy, re-accepted only after IDLE.
      snap = done_cnt;
      insn  = 32'h000013B7;
      start = 1'b1;
      step();
      step();
      step();
      chk("busy_wb_done", done32, 1);
      chk("busy_wb_data", data32, 32'h00001000);
      chk("busy_wb_addr", addr32, 7);
      step();
      chk("busy_no_b2b", busy32, 0);
      chk("busy_one_done", done_cnt - snap, 1);
      step();
      start = 1'b0;
      chk("busy_reaccept", busy32, 1);
      step();
      step();
      chk("busy_second_done", done32, 1);
      step();

      // Reset during EXEC aborts the instruction.
      snap = done_cnt;
      accept(32'hFFFFF2B7, 32'h0, 64'h0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy32, 0);
      chk("abort_we", we32, 0);
      chk("abort_data", data32, 0);
      step();
      step();
      chk("abort_no_done", done_cnt - snap, 0);
      chk("abort_still_idle", busy32, 0);

`ifdef U_SEQ_STALL_EN
      // Stall for three WB cycles: one write after it releases.
      snap = done_cnt;
      accept(32'h123452B7, 32'h0, 64'h0);
      step();
      step();
      stall = 1'b1;
      #1;
      chk("stall_we_1", we32, 0);
      chk("stall_done_1", done32, 0);
      step();
      chk("stall_we_2", we32, 0);
      chk("stall_data_2", data32, 32'h12345000);
      step();
      chk("stall_we_3", we32, 0);
      chk("stall_busy_3", busy32, 1);
      step();
      stall = 1'b0;
      #1;
      chk("stall_release_we", we32, 1);
      chk("stall_release_data", data32, 32'h12345000);
      step();
      chk("stall_idle", busy32, 0);
      chk("stall_one_done", done_cnt - snap, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/u_insn_sequencer.md
# u_insn_sequencer

Multi-cycle control sequencer for RISC-V U-type instructions (LUI, AUIPC). It is the parametrised successor to the single-cycle U-type decoder. Gated `rd_clk`/`mem_clk` outputs are replaced by a registered write-enable strobe driven from a small FSM, and the datapath width is generalised to XLEN. The block sits in the control unit between instruction fetch and the register file. It accepts one instruction per `start` handshake, computes the destination value internally and issues a single register write.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64.
- `RD_W`, 5, destination register index width.
- `clk`  in  1  processor clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  instruction valid; sampled only in IDLE.
- `insn`  in  32  instruction word; latched on accepted `start`.
- `pc`  in  XLEN  address of `insn`; latched on accepted `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse in WB.
- `illegal`  out  1  one-cycle pulse when the opcode is not LUI/AUIPC.
- `rd_we`  out  1  register-file write strobe, one cycle.
- `rd_addr`  out  RD_W  destination register, `insn[11:7]`.
- `rd_data`  out  XLEN  value to write.
- `addr_sel`, `pc_next_sel`, `pc_alu_sel`, `sub_sra`, `mem_we`  out  1 each  datapath controls; all constant 0 for U-type. `sub_sra` is driven 0, never X.

## Operation
- States:
  - IDLE → DECODE on `start`.
  - DECODE → EXEC when opcode `insn[6:0]` is 0110111 (LUI) or 0010111 (AUIPC); otherwise DECODE → ERR.
  - ERR → IDLE.
  - EXEC → WB.
  - WB → IDLE.
- On accepted `start`, `insn` and `pc` are captured into internal registers. Later changes on the input ports are ignored until the block returns to IDLE.
- Immediate: `imm = sign-extend({insn[31:12], 12'b0})` to XLEN bits.
- LUI result: `imm`.
- AUIPC result: `(pc + imm) mod 2^XLEN`. Carry out is discarded; there is no overflow flag.
- EXEC registers the result into `rd_data`; `rd_data` holds that value until the next EXEC or reset.
- WB:
  - `done` = 1.
  - `rd_we` = 1 only when `rd_addr` ≠ 0. A write to x0 is suppressed, but `done` still pulses.
- ERR: `illegal` = 1, `rd_we` = 0, `done` = 0.
- `start` while `busy` is ignored; it is not queued.
- `start` high in IDLE on the same edge the FSM leaves WB/ERR: accepted on the next edge. No back-to-back acceptance from WB.

## Timing
- Reset values: state IDLE. `busy`, `done`, `illegal`, `rd_we` = 0. `rd_addr` = 0, `rd_data` = 0. Latched `insn`/`pc` = 0.
- Reset mid-operation: returns to IDLE on that edge and aborts the instruction. No `rd_we` or `done` is issued for it.
- Let E0 be the edge at which `start` is sampled in IDLE:
  - DECODE after E0.
  - EXEC after E1.
  - WB after E2: `rd_we`, `done`, valid `rd_data`/`rd_addr`.
  - IDLE after E3.
- Valid-instruction latency: 3 cycles from the accepting edge to the `done` cycle. Throughput: one instruction per 4 cycles.
- Illegal-instruction path: `illegal` is high in the cycle after E1; IDLE after E2.
- All outputs are registered or decoded from state only. There are no combinational paths from `start`/`insn` to outputs.

## Configuration
- `U_SEQ_STALL_EN` defined:
  - Adds input `stall` (1 bit).
  - While `stall` = 1 in DECODE, EXEC or WB, the FSM holds its state and `rd_data`.
  - `rd_we` and `done` are forced 0 during stalled WB cycles, then asserted exactly once in the first unstalled WB cycle.
  - `stall` has no effect in IDLE or ERR.
  - `rst` overrides `stall`.
- `U_SEQ_STALL_EN` undefined: no `stall` port; the FSM always advances.

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0, `busy` = 0; `start` sampled together with `rst` is ignored.
- LUI, XLEN=32: `insn` = 0x123452B7 (lui x5, 0x12345) → WB at E0+3 with `rd_we` = 1, `rd_addr` = 5, `rd_data` = 0x12345000, `done` = 1 for one cycle.
- AUIPC wrap, XLEN=32: `pc` = 0xFFFFF000, `insn` = 0x00001517 (auipc x10, 1) → `rd_data` = 0x00000000, `rd_addr` = 10; AUIPC negative, XLEN=64: `pc` = 0x1000, `insn` = 0x80000197 (auipc x3, 0x80000) → `rd_data` = 0xFFFFFFFF80001000.
- Write to x0: `insn` = 0xABCDE037 → `done` = 1, `rd_we` = 0. Illegal: `insn` = 0x00000013 → `illegal` pulses one cycle after E1, no `done`, `busy` low after E2.
- Busy and abort: second `start` at E1 is ignored (exactly one `done`); `rst` asserted during EXEC → IDLE next cycle, no `rd_we`.
- With `U_SEQ_STALL_EN`: `stall` = 1 for 3 cycles starting in WB → `rd_we` = 0 during the stall, then exactly one `rd_we`/`done` pulse; `rd_data` stable throughout.
